writeback_stage: RTL and testbench

- Final pipeline stage of the core; directly upstream of RegisterFile, which it feeds.
- Accepts one completed instruction per cycle from the memory stage over a valid/ready handshake and selects the result source: ALU, load data, or PC+4.
- Sign- or zero-extends load data and drives the register file write port (wsel/wdata/wen).
- Also exports a bypass copy of the in-flight write for decode-stage forwarding and counts retired instructions.

---
 rtl/core_pkg.sv | 22 ++
 rtl/load_extend.sv | 43 ++++
 rtl/writeback_stage.sv | 103 ++++++++++
 tb/tb_writeback_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, writeback source encoding and
// RISC-V load funct3 codes used by the writeback stage.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 64;

  // Encoding 2'b11 is reserved and produces a zero result.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of an aligned load word and sign- or
// zero-extends it according to the RISC-V load funct3.
module load_extend #(
  parameter int XLEN = core_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  import core_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword loads are assumed aligned, so only addr_lo[1] picks the half.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   result = rdata;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers one completed instruction, drives the
// register file write port plus a bypass copy, and counts retired instructions.
module writeback_stage #(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int CNT_W      = core_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_src,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_mem_rdata,
  input  logic [1:0]            in_mem_addr_lo,
  input  logic [2:0]            in_load_funct3,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic                  hold,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] wsel,
  output logic [XLEN-1:0]       wdata,
  output logic                  wen,
  output logic                  byp_valid,
  output logic [REG_ADDR_W-1:0] byp_rd,
  output logic [XLEN-1:0]       byp_data,
  output logic [CNT_W-1:0]      instret
);

  import core_pkg::*;

  logic                  valid_q;
  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;
  logic [CNT_W-1:0]      instret_q;

  logic [XLEN-1:0] load_value;
  logic [XLEN-1:0] result;
  logic            accept;
  logic            retire;

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata  (in_mem_rdata),
    .addr_lo(in_mem_addr_lo),
    .funct3 (in_load_funct3),
    .result (load_value)
  );

  always_comb begin
    result = '0;
    case (in_wb_src)
      WB_ALU:  result = in_alu_result;
      WB_MEM:  result = load_value;
      WB_PC4:  result = in_pc_plus4;
      default: result = '0;
    endcase
  end

  assign in_ready = !hold && !flush;
  assign accept   = in_valid && in_ready;
  // A flushed entry is discarded in the same cycle, so it must neither retire nor write.
  assign retire   = valid_q && !hold && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!hold) begin
      valid_q <= accept;
      if (accept) begin
        reg_write_q <= in_reg_write;
        rd_q        <= in_rd;
        data_q      <= result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Writes to x0 still retire but never reach the register file.
  assign wen       = retire && reg_write_q && (rd_q != '0);
  assign wsel      = rd_q;
  assign wdata     = data_q;
  assign byp_valid = wen;
  assign byp_rd    = rd_q;
  assign byp_data  = data_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage plus hand-written sequences
// for reset, hold, flush, back-to-back accepts and counter wrap.
module tb_writeback_stage;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  wb_src;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0]  addr_lo;
    logic [2:0]  funct3;
    logic [31:0] pc4;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_src;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [1:0]  in_mem_addr_lo;
  logic [2:0]  in_load_funct3;
  logic [31:0] in_pc_plus4;
  logic        hold;
  logic        flush;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic        wen;
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
  logic [63:0] instret;

  logic        s_in_ready;
  logic [4:0]  s_wsel;
  logic [31:0] s_wdata;
  logic        s_wen;
  logic        s_byp_valid;
  logic [4:0]  s_byp_rd;
  logic [31:0] s_byp_data;
  logic [1:0]  s_instret;

  logic [31:0] rf [32];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_instret = 64'd0;
  vec_t        vecs [12];

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_src(in_wb_src),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_mem_addr_lo(in_mem_addr_lo), .in_load_funct3(in_load_funct3),
    .in_pc_plus4(in_pc_plus4), .hold(hold), .flush(flush),
    .wsel(wsel), .wdata(wdata), .wen(wen), .byp_valid(byp_valid),
    .byp_rd(byp_rd), .byp_data(byp_data), .instret(instret)
  );

  // Narrow-counter copy so the wrap to zero can be reached in a few cycles.
  writeback_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_src(in_wb_src),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_mem_addr_lo(in_mem_addr_lo), .in_load_funct3(in_load_funct3),
    .in_pc_plus4(in_pc_plus4), .hold(hold), .flush(flush),
    .wsel(s_wsel), .wdata(s_wdata), .wen(s_wen), .byp_valid(s_byp_valid),
    .byp_rd(s_byp_rd), .byp_data(s_byp_data), .instret(s_instret)
  );

  always @(posedge clk) begin
    if (wen) rf[wsel] <= wdata;
  end

  function automatic vec_t mk(input string name, input logic [4:0] rd, input logic rw,
                              input logic [1:0] src, input logic [31:0] alu,
                              input logic [1:0] alo, input logic [2:0] f3,
                              input logic [31:0] pc4, input logic ew, input logic [31:0] ed);
    vec_t v;
    v.name = name; v.rd = rd; v.reg_write = rw; v.wb_src = src; v.alu = alu;
    v.mem = 32'h80F17F02; v.addr_lo = alo; v.funct3 = f3; v.pc4 = pc4;
    v.exp_wen = ew; v.exp_wdata = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_rd = v.rd; in_reg_write = v.reg_write; in_wb_src = v.wb_src;
    in_alu_result = v.alu; in_mem_rdata = v.mem; in_mem_addr_lo = v.addr_lo;
    in_load_funct3 = v.funct3; in_pc_plus4 = v.pc4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic runAlu(input logic [4:0] rd, input logic [31:0] val);
    applyStimulus(mk("alu", rd, 1'b1, 2'b00, val, 2'd0, 3'b010, 32'd0, 1'b1, val));
    step();
    exp_instret++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    in_rd = '0; in_reg_write = 1'b0; in_wb_src = 2'b00; in_alu_result = '0;
    in_mem_rdata = '0; in_mem_addr_lo = '0; in_load_funct3 = '0; in_pc_plus4 = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    vecs[0]  = mk("alu_x5",     5'd5,  1'b1, 2'b00, 32'hDEADBEEF, 2'd0, 3'b010, 32'd0,   1'b1, 32'hDEADBEEF);
    vecs[1]  = mk("lb_a3",      5'd6,  1'b1, 2'b01, 32'd0,        2'd3, 3'b000, 32'd0,   1'b1, 32'hFFFFFF80);
    vecs[2]  = mk("lbu_a1",     5'd7,  1'b1, 2'b01, 32'd0,        2'd1, 3'b100, 32'd0,   1'b1, 32'h0000007F);
    vecs[3]  = mk("lh_a2",      5'd8,  1'b1, 2'b01, 32'd0,        2'd2, 3'b001, 32'd0,   1'b1, 32'hFFFF80F1);
    vecs[4]  = mk("lhu_a0",     5'd9,  1'b1, 2'b01, 32'd0,        2'd0, 3'b101, 32'd0,   1'b1, 32'h00007F02);
    vecs[5]  = mk("lw",         5'd11, 1'b1, 2'b01, 32'd0,        2'd0, 3'b010, 32'd0,   1'b1, 32'h80F17F02);
    vecs[6]  = mk("f3_other",   5'd12, 1'b1, 2'b01, 32'd0,        2'd1, 3'b011, 32'd0,   1'b1, 32'h80F17F02);
    vecs[7]  = mk("lh_a3",      5'd13, 1'b1, 2'b01, 32'd0,        2'd3, 3'b001, 32'd0,   1'b1, 32'hFFFF80F1);
    vecs[8]  = mk("x0_write",   5'd0,  1'b1, 2'b00, 32'h00001234, 2'd0, 3'b010, 32'd0,   1'b0, 32'h00001234);
    vecs[9]  = mk("link_pc4",   5'd1,  1'b1, 2'b10, 32'h55555555, 2'd0, 3'b010, 32'h100, 1'b1, 32'h00000100);
    vecs[10] = mk("reserved",   5'd2,  1'b1, 2'b11, 32'h55555555, 2'd0, 3'b010, 32'h100, 1'b1, 32'h00000000);
    vecs[11] = mk("no_write",   5'd3,  1'b0, 2'b00, 32'h00000055, 2'd0, 3'b010, 32'd0,   1'b0, 32'h00000055);

    step(); step();
    checkOutput("rst_wen", wen, 0);
    checkOutput("rst_instret", instret, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Asynchronous reset with an entry about to write.
    applyStimulus(mk("pend", 5'd4, 1'b1, 2'b00, 32'h0000CAFE, 2'd0, 3'b010, 32'd0, 1'b1, 32'h0000CAFE));
    checkOutput("pend_wen", wen, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_wen", wen, 0);
    checkOutput("arst_wsel", wsel, 0);
    checkOutput("arst_wdata", wdata, 0);
    checkOutput("arst_byp_valid", byp_valid, 0);
    checkOutput("arst_instret", instret, 0);
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_wen_a", wen, 0);
    step();
    checkOutput("post_rst_wen_b", wen, 0);
    checkOutput("post_rst_instret", instret, 0);
    exp_instret = 0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_wen"}, wen, vecs[i].exp_wen);
      checkOutput({vecs[i].name, "_wsel"}, wsel, vecs[i].rd);
      checkOutput({vecs[i].name, "_wdata"}, wdata, vecs[i].exp_wdata);
      checkOutput({vecs[i].name, "_byp_valid"}, byp_valid, vecs[i].exp_wen);
      checkOutput({vecs[i].name, "_byp_rd"}, byp_rd, vecs[i].rd);
      checkOutput({vecs[i].name, "_byp_data"}, byp_data, vecs[i].exp_wdata);
      checkOutput({vecs[i].name, "_instret_pre"}, instret, exp_instret);
      step();
      exp_instret++;
      checkOutput({vecs[i].name, "_instret_post"}, instret, exp_instret);
      checkOutput({vecs[i].name, "_wen_after"}, wen, 0);
    end
    checkOutput("rf_x5", rf[5], 32'hDEADBEEF);
    checkOutput("rf_x0_untouched", rf[0], 0);
    checkOutput("rf_x3_untouched", rf[3], 0);

    // Back-to-back accepts retire one per cycle.
    in_rd = 5'd20; in_reg_write = 1'b1; in_wb_src = 2'b00; in_alu_result = 32'hA1A1A1A1;
    in_valid = 1'b1;
    step();
    checkOutput("b2b_first_wdata", wdata, 32'hA1A1A1A1);
    in_rd = 5'd21; in_alu_result = 32'hA2A2A2A2;
    step();
    in_valid = 1'b0;
    checkOutput("b2b_second_wen", wen, 1);
    checkOutput("b2b_second_wsel", wsel, 21);
    checkOutput("b2b_second_wdata", wdata, 32'hA2A2A2A2);
    checkOutput("b2b_instret_mid", instret, exp_instret + 1);
    step();
    exp_instret += 2;
    checkOutput("b2b_instret_end", instret, exp_instret);

    // Hold freezes the entry, which then retires exactly once.
    in_rd = 5'd10; in_reg_write = 1'b1; in_wb_src = 2'b00; in_alu_result = 32'h12345678;
    in_valid = 1'b1;
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("hold_wen_%0d", i), wen, 0);
      checkOutput($sformatf("hold_in_ready_%0d", i), in_ready, 0);
      checkOutput($sformatf("hold_instret_%0d", i), instret, exp_instret);
      step();
    end
    in_valid = 1'b0;
    hold = 1'b0;
    #1;
    checkOutput("hold_rel_wen", wen, 1);
    checkOutput("hold_rel_wsel", wsel, 10);
    checkOutput("hold_rel_wdata", wdata, 32'h12345678);
    step();
    exp_instret++;
    checkOutput("hold_rel_instret", instret, exp_instret);
    checkOutput("hold_rel_once", wen, 0);
    checkOutput("rf_x10", rf[10], 32'h12345678);

    // Flush discards the pending entry.
    in_rd = 5'd15; in_alu_result = 32'hAAAAAAAA; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    checkOutput("flush_wen", wen, 0);
    checkOutput("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    checkOutput("flush_after_wen", wen, 0);
    checkOutput("flush_instret", instret, exp_instret);
    checkOutput("rf_x15", rf[15], 0);

    // Flush together with in_valid drops the input.
    in_rd = 5'd16; in_alu_result = 32'h00000077; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush_drop_wen", wen, 0);
    step();
    checkOutput("flush_drop_instret", instret, exp_instret);
    checkOutput("rf_x16", rf[16], 0);

    // Counter wrap on the 2-bit instance after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_instret = 0;
    runAlu(5'd1, 32'h1);
    runAlu(5'd1, 32'h2);
    runAlu(5'd1, 32'h3);
    checkOutput("small_instret_3", s_instret, 3);
    runAlu(5'd1, 32'h4);
    checkOutput("small_instret_wrap", s_instret, 0);
    checkOutput("big_instret_4", instret, exp_instret);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
